// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - register-file write port arbiter with per-register pending-write scoreboard
// Optional statistics outputs are built when REG_WRITEBACK_STATS_EN is defined.
module reg_writeback #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int LQ_DEPTH      = 4,
    parameter int CNT_WIDTH     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    input  logic [ADDRESS_WIDTH-1:0] issue_rd,
    output logic                     issue_ready,
    input  logic                     alu_valid,
    input  logic [ADDRESS_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [ADDRESS_WIDTH-1:0] ld_rd,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    input  logic [ADDRESS_WIDTH-1:0] query_addr1,
    input  logic [ADDRESS_WIDTH-1:0] query_addr2,
    output logic                     busy1,
    output logic                     busy2,
    output logic                     write_en,
    output logic [ADDRESS_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0]    write_data,
    output logic                     err_underflow
`ifdef REG_WRITEBACK_STATS_EN
    ,
    output logic [31:0]              stat_writes,
    output logic [31:0]              stat_ld_stall
`endif
);

    localparam int NREG  = 2 ** ADDRESS_WIDTH;
    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0]     cnt_q     [NREG];
    logic [CNT_WIDTH-1:0]     cnt_d     [NREG];
    logic [ADDRESS_WIDTH-1:0] lq_rd_q   [LQ_DEPTH];
    logic [ADDRESS_WIDTH-1:0] lq_rd_d   [LQ_DEPTH];
    logic [DATA_WIDTH-1:0]    lq_data_q [LQ_DEPTH];
    logic [DATA_WIDTH-1:0]    lq_data_d [LQ_DEPTH];
    logic [PTR_W:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                     write_en_q, write_en_d;
    logic [ADDRESS_WIDTH-1:0] write_addr_q, write_addr_d;
    logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
    logic                     err_q, err_d;

    logic                     lq_empty, lq_full, lq_pop, ld_push, issue_fire;
    logic                     sel_valid, sel_we;
    logic [ADDRESS_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0]    sel_data;

    // The extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign lq_empty   = (wr_ptr_q == rd_ptr_q);
    assign lq_full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign ld_ready   = !lq_full;
    assign ld_push    = ld_valid && !lq_full;
    assign issue_ready = (issue_rd == '0) || (cnt_q[issue_rd] != CNT_MAX);
    assign issue_fire = issue_valid && issue_ready;

    // ALU has strict priority; a load is only popped when the ALU slot is idle.
    assign lq_pop    = !alu_valid && !lq_empty;
    assign sel_valid = alu_valid || !lq_empty;
    assign sel_rd    = alu_valid ? alu_rd   : lq_rd_q[rd_ptr_q[PTR_W-1:0]];
    assign sel_data  = alu_valid ? alu_data : lq_data_q[rd_ptr_q[PTR_W-1:0]];
    assign sel_we    = sel_valid && (sel_rd != '0);

    // Register 0 is never counted, so its busy flags are always low.
    assign busy1         = (cnt_q[query_addr1] != '0);
    assign busy2         = (cnt_q[query_addr2] != '0);
    assign write_en      = write_en_q;
    assign write_addr    = write_addr_q;
    assign write_data    = write_data_q;
    assign err_underflow = err_q;

    // Load queue storage and pointer update.
    always_comb begin
        lq_rd_d   = lq_rd_q;
        lq_data_d = lq_data_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (ld_push) begin
            lq_rd_d[wr_ptr_q[PTR_W-1:0]]   = ld_rd;
            lq_data_d[wr_ptr_q[PTR_W-1:0]] = ld_data;
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (lq_pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    // Write stage: address/data only move when a real write is launched.
    always_comb begin
        write_en_d   = sel_we;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        if (sel_we) begin
            write_addr_d = sel_rd;
            write_data_d = sel_data;
        end
    end

    // Pending counters: retire takes effect on the edge that raises write_en so busy drops with it.
    always_comb begin
        err_d = err_q || (sel_we && (cnt_q[sel_rd] == '0));
        for (int i = 0; i < NREG; i++) begin
            logic inc, dec;
            inc = issue_fire && (issue_rd == ADDRESS_WIDTH'(i)) && (i != 0);
            dec = sel_we && (sel_rd == ADDRESS_WIDTH'(i));
            cnt_d[i] = cnt_q[i];
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end else if (dec && !inc && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                lq_rd_q[i]   <= '0;
                lq_data_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            lq_rd_q      <= lq_rd_d;
            lq_data_q    <= lq_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            err_q        <= err_d;
        end
    end

`ifdef REG_WRITEBACK_STATS_EN
    logic [31:0] stat_writes_q, stat_writes_d, stat_ld_stall_q, stat_ld_stall_d;

    // Free-running event counters; wrap naturally.
    always_comb begin
        stat_writes_d   = stat_writes_q + (write_en_q ? 32'd1 : 32'd0);
        stat_ld_stall_d = stat_ld_stall_q + ((alu_valid && !lq_empty) ? 32'd1 : 32'd0);
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_writes_q   <= '0;
            stat_ld_stall_q <= '0;
        end else begin
            stat_writes_q   <= stat_writes_d;
            stat_ld_stall_q <= stat_ld_stall_d;
        end
    end

    assign stat_writes   = stat_writes_q;
    assign stat_ld_stall = stat_ld_stall_q;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - scoreboard bench for reg_writeback against a queue/array reference model
module tb_reg_writeback;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LQD = 4;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_rd = '0;
    logic          issue_ready;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [AW-1:0] ld_rd = '0;
    logic [DW-1:0] ld_data = '0;
    logic [AW-1:0] query_addr1 = '0;
    logic [AW-1:0] query_addr2 = '0;
    logic          busy1, busy2;
    logic          write_en;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic          err_underflow;

    reg_writeback #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LQ_DEPTH(LQD), .CNT_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .query_addr1(query_addr1), .query_addr2(query_addr2),
        .busy1(busy1), .busy2(busy2),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending counts per register, load FIFO contents, sticky error.
    int             cnt_m [32];
    logic [AW+DW-1:0] lq_m [$];
    logic [AW+DW-1:0] exp_q [$];
    logic           err_m = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) cnt_m[i] = 0;
        lq_m.delete();
        exp_q.delete();
        err_m = 1'b0;
    endtask

    // One clock of stimulus: drive, check combinational outputs vs. model, advance model.
    task automatic cycle(input logic iv, input logic [AW-1:0] ird,
                         input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldat,
                         input logic [AW-1:0] q1, input logic [AW-1:0] q2);
        logic exp_ir, exp_lr, have;
        logic [AW+DW-1:0] sel;
        @(negedge clk);
        issue_valid = iv; issue_rd = ird;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_valid = lv; ld_rd = lrd; ld_data = ldat;
        query_addr1 = q1; query_addr2 = q2;
        #1;
        exp_ir = (ird == 0) || (cnt_m[ird] != CMAX);
        exp_lr = (lq_m.size() < LQD);
        chk("issue_ready", 64'(issue_ready), 64'(exp_ir));
        chk("ld_ready", 64'(ld_ready), 64'(exp_lr));
        chk("busy1", 64'(busy1), 64'(cnt_m[q1] != 0));
        chk("busy2", 64'(busy2), 64'(cnt_m[q2] != 0));
        chk("err_underflow", 64'(err_underflow), 64'(err_m));
        have = 1'b0;
        sel = '0;
        if (av) begin
            have = 1'b1;
            sel = {ard, ad};
        end else if (lq_m.size() != 0) begin
            have = 1'b1;
            sel = lq_m.pop_front();
        end
        if (iv && exp_ir && ird != 0) cnt_m[ird]++;
        if (have && sel[AW+DW-1:DW] != 0) begin
            exp_q.push_back(sel);
            if (cnt_m[sel[AW+DW-1:DW]] == 0 || (iv && exp_ir && ird == sel[AW+DW-1:DW] && cnt_m[ird] == 1))
                err_m = (cnt_m[sel[AW+DW-1:DW]] == 0 || (iv && exp_ir && ird == sel[AW+DW-1:DW] && cnt_m[ird] == 1)) ? 1'b1 : err_m;
            if (cnt_m[sel[AW+DW-1:DW]] > 0) cnt_m[sel[AW+DW-1:DW]]--;
        end
        if (lv && exp_lr) lq_m.push_back({lrd, ldat});
    endtask

    task automatic idle(input logic [AW-1:0] q1, input logic [AW-1:0] q2);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, q1, q2);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must react without a clock edge.
    task automatic mid_reset(input logic [AW-1:0] q);
        @(posedge clk);
        #2;
        issue_valid = 0; alu_valid = 0; ld_valid = 0;
        query_addr1 = q; query_addr2 = q;
        rst_n = 1'b0;
        #1;
        chk("rst_write_en", 64'(write_en), 64'd0);
        chk("rst_ld_ready", 64'(ld_ready), 64'd1);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_err", 64'(err_underflow), 64'd0);
        model_clear();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && write_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", write_addr, write_data);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                chk("write_addr", 64'(write_addr), 64'(e[AW+DW-1:DW]));
                chk("write_data", 64'(write_data), 64'(e[DW-1:0]));
            end
        end
    end

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        chk("reset_write_en", 64'(write_en), 64'd0);
        chk("reset_write_addr", 64'(write_addr), 64'd0);
        chk("reset_write_data", 64'(write_data), 64'd0);
        chk("reset_ld_ready", 64'(ld_ready), 64'd1);
        chk("reset_issue_ready", 64'(issue_ready), 64'd1);
        #2 rst_n = 1'b1;

        // Issue rd=5, ALU result next cycle, busy clears with the write.
        cycle(1, 5, 0, 0, 0, 0, 0, 0, 5, 0);
        cycle(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
        chk("t1_busy_pending", 64'(busy1), 64'd1);
        idle(5, 0);
        chk("t1_busy_after", 64'(busy1), 64'd0);

        // Four loads queued behind a 5-cycle ALU burst, then drained in order.
        for (int i = 1; i <= 4; i++) cycle(1, AW'(i), 0, 0, 0, 0, 0, 0, AW'(i), 0);
        for (int i = 0; i < 5; i++)
            cycle(0, 0, 1, 0, 32'h1111, i < 4, AW'(i + 1), 32'h100 + DW'(i), 1, 4);
        chk("t2_ld_ready_full", 64'(ld_ready), 64'd0);
        for (int i = 0; i < 5; i++) idle(1, 4);

        // Counter saturation on rd=7; rd=8 still accepted.
        for (int i = 0; i < 3; i++) cycle(1, 7, 0, 0, 0, 0, 0, 0, 7, 8);
        cycle(1, 7, 0, 0, 0, 0, 0, 0, 7, 8);
        chk("t3_issue_ready_7", 64'(issue_ready), 64'd0);
        issue_valid = 1'b0;
        issue_rd = 8;
        #1 chk("t3_issue_ready_8", 64'(issue_ready), 64'd1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 7, DW'(i), 0, 0, 0, 7, 8);
        idle(7, 8);

        // rd=0 results are consumed without a write.
        cycle(1, 0, 1, 0, 32'h1234, 1, 0, 32'h55, 0, 0);
        idle(0, 0);
        idle(0, 0);

        // Retire with no pending issue sets the sticky error.
        cycle(0, 0, 1, 9, 32'h99, 0, 0, 0, 9, 0);
        idle(9, 0);
        chk("t5_err_set", 64'(err_underflow), 64'd1);
        idle(9, 0);

        // Reset with two queued loads and cnt[3]=2.
        cycle(1, 3, 1, 10, 32'hA, 1, 1, 32'hB1, 3, 3);
        cycle(1, 3, 1, 11, 32'hA, 1, 2, 32'hB2, 3, 3);
        chk("t6_busy_before", 64'(busy1), 64'd1);
        mid_reset(3);
        for (int i = 0; i < 3; i++) idle(3, 1);

        // Randomized traffic with periodic mid-cycle resets.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 120; i++)
                cycle(1'($urandom % 2), AW'($urandom % 8),
                      1'(($urandom % 3) == 0), AW'($urandom % 8), $urandom,
                      1'($urandom % 2), AW'($urandom % 8), $urandom,
                      AW'($urandom % 8), AW'($urandom % 8));
            for (int i = 0; i < 6; i++) idle(AW'($urandom % 8), 0);
            chk("drain_empty", 64'(exp_q.size()), 64'd0);
            mid_reset(AW'($urandom % 8));
        end

        for (int i = 0; i < 4; i++) idle(0, 0);
        chk("final_no_pending", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
